// File: rtl/pipe_interlock.sv
// rtl/pipe_interlock.sv - TinyRISC hazard/sequencing controller (optional macro PIPE_INTERLOCK_PERF_EN)
module pipe_interlock #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        of_valid,
    input  logic [3:0]  of_rs1,
    input  logic [3:0]  of_rs2,
    input  logic        of_uses_rs1,
    input  logic        of_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_isWb,
    input  logic [3:0]  ex_rd,
    input  logic        ex_isMul,
    input  logic        ex_isDiv,
    input  logic        ex_branch_taken,
    input  logic        ma_valid,
    input  logic        ma_isWb,
    input  logic [3:0]  ma_rd,
    input  logic        wb_valid,
    input  logic        wb_isWb,
    input  logic [3:0]  wb_rd,
    output logic        stall_IF,
    output logic        stall_OF,
    output logic        bubble_EX,
    output logic        hold_EX,
    output logic        flush,
    output logic        isConflict_rs1,
    output logic        isConflict_rs2,
    output logic        busy,
    output logic [31:0] stall_count
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    // cnt is loaded with N-2: the IDLE cycle and the final MULTI cycle are not counted
    localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0);
    localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_CYCLES >= 2) ? (DIV_CYCLES - 2) : 0);
    localparam logic          MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic          DIV_MULTI = (DIV_CYCLES > 1);

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic hit_ex_rs1, hit_ma_rs1, hit_wb_rs1;
    logic hit_ex_rs2, hit_ma_rs2, hit_wb_rs2;
    logic dhaz;
    logic byp_rs1, byp_rs2;
    logic branch_now;
    logic multi_start;
    logic [CW-1:0] multi_load;

    logic r_stall_IF, r_stall_OF, r_bubble_EX, r_hold_EX, r_flush;
    logic r_conf_rs1, r_conf_rs2, r_busy;

    assign hit_ex_rs1 = ex_valid & ex_isWb & (ex_rd == of_rs1);
    assign hit_ma_rs1 = ma_valid & ma_isWb & (ma_rd == of_rs1);
    assign hit_wb_rs1 = wb_valid & wb_isWb & (wb_rd == of_rs1);
    assign hit_ex_rs2 = ex_valid & ex_isWb & (ex_rd == of_rs2);
    assign hit_ma_rs2 = ma_valid & ma_isWb & (ma_rd == of_rs2);
    assign hit_wb_rs2 = wb_valid & wb_isWb & (wb_rd == of_rs2);

    assign dhaz = of_valid & ((of_uses_rs1 & (hit_ex_rs1 | hit_ma_rs1)) |
                              (of_uses_rs2 & (hit_ex_rs2 | hit_ma_rs2)));

    assign byp_rs1 = of_valid & of_uses_rs1 & hit_wb_rs1 & ~dhaz;
    assign byp_rs2 = of_valid & of_uses_rs2 & hit_wb_rs2 & ~dhaz;

    assign branch_now  = ex_valid & ex_branch_taken;
    assign multi_start = ex_valid & ((ex_isMul & MUL_MULTI) | (~ex_isMul & ex_isDiv & DIV_MULTI));
    assign multi_load  = ex_isMul ? MUL_LOAD : DIV_LOAD;

    // Control decode from current state and inputs, in IDLE priority order
    always_comb begin
        r_stall_IF  = 1'b0;
        r_stall_OF  = 1'b0;
        r_bubble_EX = 1'b0;
        r_hold_EX   = 1'b0;
        r_flush     = 1'b0;
        r_conf_rs1  = 1'b0;
        r_conf_rs2  = 1'b0;
        r_busy      = 1'b0;
        if (state == MULTI) begin
            r_stall_IF = 1'b1;
            r_stall_OF = 1'b1;
            r_hold_EX  = (cnt != '0);
            r_busy     = 1'b1;
        end else if (branch_now) begin
            r_flush     = 1'b1;
            r_bubble_EX = 1'b1;
        end else if (multi_start) begin
            r_hold_EX  = 1'b1;
            r_stall_IF = 1'b1;
            r_stall_OF = 1'b1;
            r_conf_rs1 = byp_rs1;
            r_conf_rs2 = byp_rs2;
        end else if (dhaz) begin
            r_stall_IF  = 1'b1;
            r_stall_OF  = 1'b1;
            r_bubble_EX = 1'b1;
        end else begin
            r_conf_rs1 = byp_rs1;
            r_conf_rs2 = byp_rs2;
        end
    end

    // Reset forces every output low regardless of the pipeline inputs
    assign stall_IF       = r_stall_IF  & rst_n;
    assign stall_OF       = r_stall_OF  & rst_n;
    assign bubble_EX      = r_bubble_EX & rst_n;
    assign hold_EX        = r_hold_EX   & rst_n;
    assign flush          = r_flush     & rst_n;
    assign isConflict_rs1 = r_conf_rs1  & rst_n;
    assign isConflict_rs2 = r_conf_rs2  & rst_n;
    assign busy           = r_busy      & rst_n;

    // Multi-cycle sequencer: IDLE launches MULTI, MULTI counts down then releases EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!branch_now && multi_start) begin
                        state <= MULTI;
                        cnt   <= multi_load;
                    end
                end
                MULTI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_INTERLOCK_PERF_EN
    logic [31:0] perf_cnt;

    // Saturating count of cycles in which OF was held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (stall_OF && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_count = perf_cnt;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_interlock.sv
// tb/tb_pipe_interlock.sv - directed self-checking bench for pipe_interlock
module tb_pipe_interlock;

    logic        clk;
    logic        rst_n;
    logic        of_valid;
    logic [3:0]  of_rs1;
    logic [3:0]  of_rs2;
    logic        of_uses_rs1;
    logic        of_uses_rs2;
    logic        ex_valid;
    logic        ex_isWb;
    logic [3:0]  ex_rd;
    logic        ex_isMul;
    logic        ex_isDiv;
    logic        ex_branch_taken;
    logic        ma_valid;
    logic        ma_isWb;
    logic [3:0]  ma_rd;
    logic        wb_valid;
    logic        wb_isWb;
    logic [3:0]  wb_rd;
    logic        stall_IF;
    logic        stall_OF;
    logic        bubble_EX;
    logic        hold_EX;
    logic        flush;
    logic        isConflict_rs1;
    logic        isConflict_rs2;
    logic        busy;
    logic [31:0] stall_count;

    logic [7:0]  ctrl;
    int          n_checks;
    int          n_fail;

    // ctrl bit order: stall_IF stall_OF bubble_EX hold_EX flush conf_rs1 conf_rs2 busy
    localparam logic [7:0] C_NONE    = 8'b0000_0000;
    localparam logic [7:0] C_STALL   = 8'b1110_0000;
    localparam logic [7:0] C_BYP1    = 8'b0000_0100;
    localparam logic [7:0] C_BYP2    = 8'b0000_0010;
    localparam logic [7:0] C_M_START = 8'b1101_0000;
    localparam logic [7:0] C_M_HOLD  = 8'b1101_0001;
    localparam logic [7:0] C_M_LAST  = 8'b1100_0001;
    localparam logic [7:0] C_BRANCH  = 8'b0010_1000;

`ifdef PIPE_INTERLOCK_PERF_EN
    localparam logic [31:0] MUL_STALLS = 32'd3;
`else
    localparam logic [31:0] MUL_STALLS = 32'd0;
`endif

    assign ctrl = {stall_IF, stall_OF, bubble_EX, hold_EX, flush,
                   isConflict_rs1, isConflict_rs2, busy};

    pipe_interlock #(
        .MUL_CYCLES(3),
        .DIV_CYCLES(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .of_valid       (of_valid),
        .of_rs1         (of_rs1),
        .of_rs2         (of_rs2),
        .of_uses_rs1    (of_uses_rs1),
        .of_uses_rs2    (of_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_isWb        (ex_isWb),
        .ex_rd          (ex_rd),
        .ex_isMul       (ex_isMul),
        .ex_isDiv       (ex_isDiv),
        .ex_branch_taken(ex_branch_taken),
        .ma_valid       (ma_valid),
        .ma_isWb        (ma_isWb),
        .ma_rd          (ma_rd),
        .wb_valid       (wb_valid),
        .wb_isWb        (wb_isWb),
        .wb_rd          (wb_rd),
        .stall_IF       (stall_IF),
        .stall_OF       (stall_OF),
        .bubble_EX      (bubble_EX),
        .hold_EX        (hold_EX),
        .flush          (flush),
        .isConflict_rs1 (isConflict_rs1),
        .isConflict_rs2 (isConflict_rs2),
        .busy           (busy),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        of_valid = 0; of_rs1 = 0; of_rs2 = 0; of_uses_rs1 = 0; of_uses_rs2 = 0;
        ex_valid = 0; ex_isWb = 0; ex_rd = 0; ex_isMul = 0; ex_isDiv = 0; ex_branch_taken = 0;
        ma_valid = 0; ma_isWb = 0; ma_rd = 0;
        wb_valid = 0; wb_isWb = 0; wb_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 0;
        #2;
        rst_n = 1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        clear_inputs();
        // hazard and branch inputs present during reset must not leak out
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 3;
        ex_valid = 1; ex_isWb = 1; ex_rd = 3; ex_branch_taken = 1;
        #3;
        check("reset_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
        check("reset_count", stall_count, 32'd0);
        tick();
        clear_inputs();
        rst_n = 1;
        #1;
        check("idle_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});

        // EX producer: two stall cycles then WB bypass
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 3; of_uses_rs2 = 1; of_rs2 = 8;
        ex_valid = 1; ex_isWb = 1; ex_rd = 3;
        #1; check("ex_haz_c1", {24'd0, ctrl}, {24'd0, C_STALL});
        tick();
        ex_valid = 0; ma_valid = 1; ma_isWb = 1; ma_rd = 3;
        #1; check("ex_haz_c2", {24'd0, ctrl}, {24'd0, C_STALL});
        tick();
        ma_valid = 0; wb_valid = 1; wb_isWb = 1; wb_rd = 3;
        #1; check("ex_haz_byp", {24'd0, ctrl}, {24'd0, C_BYP1});
        tick();
        clear_inputs();
        #1; check("ex_haz_done", {24'd0, ctrl}, {24'd0, C_NONE});

        // MA producer on rs2: one stall then bypass
        of_valid = 1; of_uses_rs2 = 1; of_rs2 = 6;
        ma_valid = 1; ma_isWb = 1; ma_rd = 6;
        #1; check("ma_haz_c1", {24'd0, ctrl}, {24'd0, C_STALL});
        tick();
        ma_valid = 0; wb_valid = 1; wb_isWb = 1; wb_rd = 6;
        #1; check("ma_haz_byp", {24'd0, ctrl}, {24'd0, C_BYP2});
        tick();
        clear_inputs();

        // MUL with MUL_CYCLES=3
        do_reset();
        ex_valid = 1; ex_isWb = 1; ex_rd = 7; ex_isMul = 1;
        #1; check("mul_c1", {24'd0, ctrl}, {24'd0, C_M_START});
        tick();
        check("mul_c2", {24'd0, ctrl}, {24'd0, C_M_HOLD});
        tick();
        check("mul_c3", {24'd0, ctrl}, {24'd0, C_M_LAST});
        tick();
        clear_inputs();
        #1; check("mul_after", {24'd0, ctrl}, {24'd0, C_NONE});
        check("mul_count", stall_count, MUL_STALLS);

        // DIV with reset pulsed mid-hold
        ex_valid = 1; ex_isWb = 1; ex_rd = 2; ex_isDiv = 1;
        #1; check("div_c1", {24'd0, ctrl}, {24'd0, C_M_START});
        tick(); tick(); tick();
        check("div_c4", {24'd0, ctrl}, {24'd0, C_M_HOLD});
        rst_n = 0;
        #1;
        check("div_rst_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
        check("div_rst_count", stall_count, 32'd0);
        clear_inputs();
        #1;
        rst_n = 1;
        tick();
        check("div_rst_idle", {24'd0, ctrl}, {24'd0, C_NONE});

        // taken branch overrides a data hazard
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 3;
        ex_valid = 1; ex_isWb = 1; ex_rd = 3; ex_branch_taken = 1;
        #1; check("branch_ctrl", {24'd0, ctrl}, {24'd0, C_BRANCH});
        tick();
        clear_inputs();

        // st reading rd=r5 as rs2, WB writes r5
        of_valid = 1; of_uses_rs2 = 1; of_rs2 = 5;
        wb_valid = 1; wb_isWb = 1; wb_rd = 5;
        #1; check("st_byp", {24'd0, ctrl}, {24'd0, C_BYP2});
        wb_isWb = 0;
        #1; check("st_nowb", {24'd0, ctrl}, {24'd0, C_NONE});
        clear_inputs();

        // immediate add: rs2 field matches EX rd but is not read
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 1; of_uses_rs2 = 0; of_rs2 = 4;
        ex_valid = 1; ex_isWb = 1; ex_rd = 4;
        #1; check("imm_nostall", {24'd0, ctrl}, {24'd0, C_NONE});

        // invalid OF slot never stalls
        of_valid = 0; of_uses_rs2 = 1;
        #1; check("of_invalid", {24'd0, ctrl}, {24'd0, C_NONE});
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_interlock.md
# pipe_interlock

Hazard and sequencing controller for the five-stage TinyRISC pipeline (IF, OF, EX, MA, WB). It watches the source registers of the instruction in OF and the destinations of the instructions in EX, MA and WB. From these it stalls IF/OF, inserts bubbles into the OF/EX register, holds EX for multi-cycle MUL/DIV/MOD, flushes on taken branches, and drives the WB-bypass selects `isConflict_rs1` and `isConflict_rs2` consumed by OF.

## Interface
Parameters:
- `MUL_CYCLES`, default 3: total EX occupancy of MUL in cycles; must be ≥1.
- `DIV_CYCLES`, default 8: total EX occupancy of DIV/MOD in cycles; must be ≥1.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `of_valid` in 1: OF holds a real instruction.
- `of_rs1`, `of_rs2` in 4: OF operand addresses, after ret→r15 and st→rd selection.
- `of_uses_rs1`, `of_uses_rs2` in 1: the operand is actually read. `of_uses_rs2` is 0 for immediate non-st instructions.
- `ex_valid`, `ex_isWb` in 1, `ex_rd` in 4: EX producer.
- `ex_isMul`, `ex_isDiv` in 1: EX instruction is MUL, or is DIV/MOD.
- `ex_branch_taken` in 1: EX resolved a taken branch, call or ret.
- `ma_valid`, `ma_isWb` in 1, `ma_rd` in 4: MA producer.
- `wb_valid`, `wb_isWb` in 1, `wb_rd` in 4: WB producer.
- `stall_IF` out 1: PC and IF/OF register hold.
- `stall_OF` out 1: OF instruction is not consumed.
- `bubble_EX` out 1: OF/EX register loads a NOP; all control-word bits are 0.
- `hold_EX` out 1: OF/EX, EX/MA and EX state hold.
- `flush` out 1: IF/OF register loads a NOP.
- `isConflict_rs1`, `isConflict_rs2` out 1: OF takes `wbData` instead of the register-file value.
- `busy` out 1: FSM is in MULTI.
- `stall_count` out 32: performance counter (see Configuration).

## Operation
- Match term: `hit_X(rs) = X_valid & X_isWb & (X_rd == rs)`.
- Data hazard: `dhaz = of_valid & ((of_uses_rs1 & (hit_EX(of_rs1) | hit_MA(of_rs1))) | (of_uses_rs2 & (hit_EX(of_rs2) | hit_MA(of_rs2))))`.
- Bypass: `isConflict_rsN = of_valid & of_uses_rsN & hit_WB(of_rsN) & ~dhaz`.
- FSM has two states, IDLE and MULTI, plus a down-counter `cnt`. `N` is `MUL_CYCLES` if `ex_isMul`, else `DIV_CYCLES`.
- Priority in IDLE, highest first:
  1. `ex_valid & ex_branch_taken`: `flush=1`, `bubble_EX=1`, stalls 0, bypasses 0.
  2. `ex_valid & (ex_isMul|ex_isDiv) & N>1`: `hold_EX=1`, `stall_IF=stall_OF=1`, `bubble_EX=0`. Next state is MULTI with `cnt=N-2`.
  3. `dhaz`: `stall_IF=stall_OF=bubble_EX=1`.
  4. Otherwise all control outputs are 0.
- In MULTI:
  - `stall_IF=stall_OF=1`, `bubble_EX=0`, `flush=0`, bypasses 0.
  - While `cnt≠0`: `hold_EX=1` and `cnt` decrements.
  - When `cnt==0`: `hold_EX=0`. The instruction leaves EX on this edge and the next state is IDLE.
  - `ex_branch_taken` is ignored in MULTI.
- Result: the multi-cycle instruction occupies EX for exactly N cycles. Any `dhaz` against it is re-evaluated in IDLE after release.
- `cnt` width is `$clog2(max(MUL_CYCLES,DIV_CYCLES))+1`.

## Timing
- All control outputs are combinational from the state and the current inputs. `state`, `cnt` and `stall_count` are registered.
- A stall of N-stage depth resolves without further action as producers advance:
  - EX producer: 2 stall cycles, then the bypass from WB.
  - MA producer: 1 stall cycle, then the bypass.
- Reset, asynchronous, may arrive mid-MULTI:
  - state returns to IDLE and `cnt` is cleared.
  - `stall_count` is cleared.
  - All outputs are 0 while `rst_n=0`, irrespective of the other inputs.
- First valid decision is at the first rising edge after `rst_n` deasserts.
- With `MUL_CYCLES=1` or `DIV_CYCLES=1`, that op never enters MULTI and no hold is generated.

## Configuration
- `PIPE_INTERLOCK_PERF_EN` defined: `stall_count` increments on every rising edge where `stall_OF=1`, and saturates at 0xFFFFFFFF.
- Not defined: the counter logic is absent and `stall_count` is tied to 0.

## Test plan
- EX `add r3` (`ex_isWb=1`, `ex_rd=3`); OF `sub` reading `of_rs1=3` → `stall_IF=stall_OF=bubble_EX=1` for 2 cycles, then `isConflict_rs1=1` for 1 cycle, then all 0.
- EX `mul` with `MUL_CYCLES=3` → `hold_EX=1` for 2 cycles, `busy=1` on the 2nd cycle, 3rd cycle `hold_EX=0`, back to IDLE. With the macro defined, `stall_count=3`.
- EX `div` with `DIV_CYCLES=8` and `rst_n` pulsed low at hold cycle 4 → all outputs 0 immediately, `busy=0`, `stall_count=0`.
- EX `beq` taken while OF has `dhaz` → `flush=1`, `bubble_EX=1`, `stall_IF=0`, `isConflict_rs*=0`.
- OF `st` with `of_rs2=5` (rd), WB writing r5, no EX/MA match → `isConflict_rs2=1`, no stall. The same case with `wb_isWb=0` → `isConflict_rs2=0`.
- Immediate `add` (`of_uses_rs2=0`) with `of_rs2` matching `ex_rd` → no stall.
